// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes and transmitter state encoding.
// The future receiver imports the same package.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  // S_ prefix keeps these names clear of the PARITY parameter of the transmitter.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps.
// tick is high during the last cycle of a bit period, so the owner advances on the wrap edge.
// pre_tick is high one cycle earlier, which lets the owner raise a registered flag on the wrap cycle itself.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on clear, wrap at the end of the period, otherwise increment.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // Period counter register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick     = (cnt_q == CNT_LAST);
  assign pre_tick = (cnt_q == CNT_PRE);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: one word per valid/ready handshake is sent as
// start bit, DATA_BITS data bits LSB first, optional parity bit and 1 or 2 stop bits,
// each bit held for CLKS_PER_BIT clocks. tx_ready rises in the last cycle of the
// final stop bit so a new word can be accepted on the edge that ends the frame.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = 434,
  parameter int      DATA_BITS    = 8,
  parameter parity_e PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy
);

  localparam int BI_W = $clog2(DATA_BITS + 1);

  localparam logic [2:0] ST_IDLE   = S_IDLE;
  localparam logic [2:0] ST_START  = S_START;
  localparam logic [2:0] ST_DATA   = S_DATA;
  localparam logic [2:0] ST_PARITY = S_PARITY;
  localparam logic [2:0] ST_STOP   = S_STOP;

  localparam logic [BI_W-1:0] BIT_LAST  = BI_W'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  // Parity over the latched word; even mode makes the total count of ones even.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    case (PARITY)
      PAR_EVEN: return ^d;
      PAR_ODD:  return ~^d;
      default:  return 1'b0;
    endcase
  endfunction

  logic [2:0]           state_q,    state_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic [BI_W-1:0]      bit_idx_q,  bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 parity_q,   parity_d;
  logic                 tx_q,       tx_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 busy_q,     busy_d;

  logic accept;
  logic timer_clear;
  logic bit_tick;
  logic bit_pre_tick;
  logic last_stop;

  assign accept      = tx_valid && tx_ready_q;
  // Hold the timer at zero while idle and restart it on every accepted word,
  // so the start bit always lasts exactly one full period from the handshake edge.
  assign timer_clear = accept || (state_q == ST_IDLE);
  assign last_stop   = (stop_idx_q == STOP_LAST);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .tick    (bit_tick),
    .pre_tick(bit_pre_tick)
  );

  // Frame sequencing: an accepted word always wins and starts a new frame,
  // otherwise the current state advances on the bit-period wrap.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;

    if (accept) begin
      state_d    = ST_START;
      shift_d    = tx_data;
      parity_d   = calc_parity(tx_data);
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
      tx_d       = 1'b0;
      tx_ready_d = 1'b0;
      busy_d     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_d       = 1'b1;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
        ST_START: begin
          if (bit_tick) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_idx_q == BIT_LAST) begin
              if (PARITY != PAR_NONE) begin
                state_d = ST_PARITY;
                tx_d    = parity_q;
              end else begin
                state_d    = ST_STOP;
                stop_idx_d = 1'b0;
                tx_d       = 1'b1;
              end
            end else begin
              bit_idx_d = bit_idx_q + BI_W'(1);
              tx_d      = shift_q[0];
              shift_d   = shift_q >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            state_d    = ST_STOP;
            stop_idx_d = 1'b0;
            tx_d       = 1'b1;
          end
        end
        ST_STOP: begin
          // Raise ready one cycle before the frame ends so a waiting producer
          // handshakes exactly on the closing edge.
          if (bit_pre_tick && last_stop) begin
            tx_ready_d = 1'b1;
          end
          if (bit_tick) begin
            if (last_stop) begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end else begin
              stop_idx_d = stop_idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          tx_d       = 1'b1;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      endcase
    end
  end

  // Control and output registers; reset abandons any frame in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  // Word and parity registers; only meaningful while a frame is in flight.
  always_ff @(posedge clock) begin
    shift_q  <= shift_d;
    parity_q <= parity_d;
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: six parameter sets run side by side against a
// frame-level model (bit list + position counter), plus literal waveform pins.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int NCFG = 6;
  localparam int CAPN = 100;

  function automatic int cpb_of(input int i);
    case (i)
      4:       return 3;
      5:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int db_of(input int i);
    case (i)
      3:       return 7;
      4:       return 9;
      5:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic parity_e par_of(input int i);
    case (i)
      1:       return PAR_EVEN;
      2:       return PAR_ODD;
      4:       return PAR_ODD;
      5:       return PAR_EVEN;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic int sb_of(input int i);
    case (i)
      3:       return 2;
      4:       return 2;
      default: return 1;
    endcase
  endfunction

  logic       clock = 1'b0;
  logic       reset_n;
  logic       tx_valid_a [NCFG];
  logic [8:0] tx_data_a  [NCFG];
  logic       tx_a       [NCFG];
  logic       rdy_a      [NCFG];
  logic       busy_a     [NCFG];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int DB = db_of(g);
    uart_tx_frame #(
      .CLKS_PER_BIT(cpb_of(g)),
      .DATA_BITS   (DB),
      .PARITY      (par_of(g)),
      .STOP_BITS   (sb_of(g))
    ) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .tx_valid(tx_valid_a[g]),
      .tx_ready(rdy_a[g]),
      .tx_data (tx_data_a[g][DB-1:0]),
      .tx      (tx_a[g]),
      .busy    (busy_a[g])
    );
  end

  // Frame-level model: the list of line levels for one frame and the cycle position in it.
  bit   m_active [NCFG];
  int   m_pos    [NCFG];
  int   m_nbits  [NCFG];
  logic m_bits   [NCFG][13];

  int tests = 0;
  int fails = 0;

  logic cap_tx   [NCFG][CAPN];
  logic cap_rdy  [NCFG][CAPN];
  logic cap_busy [NCFG][CAPN];
  int   cap_idx = CAPN;

  function automatic int frame_len(input int i);
    return m_nbits[i] * cpb_of(i);
  endfunction

  function automatic logic exp_tx(input int i);
    if (!m_active[i]) return 1'b1;
    return m_bits[i][m_pos[i] / cpb_of(i)];
  endfunction

  function automatic logic exp_ready(input int i);
    if (!m_active[i]) return 1'b1;
    return (m_pos[i] == frame_len(i) - 1);
  endfunction

  function automatic logic exp_busy(input int i);
    return m_active[i];
  endfunction

  task automatic build_frame(input int i, input logic [8:0] w);
    int n;
    int ones;
    logic [8:0] m;
    m = w & 9'((1 << db_of(i)) - 1);
    n = 0;
    m_bits[i][n] = 1'b0;
    n = n + 1;
    for (int b = 0; b < db_of(i); b++) begin
      m_bits[i][n] = m[b];
      n = n + 1;
    end
    ones = $countones(m);
    if (par_of(i) == PAR_EVEN) begin
      m_bits[i][n] = ((ones % 2) == 1);
      n = n + 1;
    end else if (par_of(i) == PAR_ODD) begin
      m_bits[i][n] = ((ones % 2) == 0);
      n = n + 1;
    end
    for (int s = 0; s < sb_of(i); s++) begin
      m_bits[i][n] = 1'b1;
      n = n + 1;
    end
    m_nbits[i] = n;
  endtask

  task automatic model_edge();
    for (int i = 0; i < NCFG; i++) begin
      if (!reset_n) begin
        m_active[i] = 1'b0;
        m_pos[i]    = 0;
      end else if (tx_valid_a[i] && exp_ready(i)) begin
        build_frame(i, tx_data_a[i]);
        m_active[i] = 1'b1;
        m_pos[i]    = 0;
      end else if (m_active[i]) begin
        m_pos[i] = m_pos[i] + 1;
        if (m_pos[i] >= frame_len(i)) begin
          m_active[i] = 1'b0;
          m_pos[i]    = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int i, input logic act, input logic exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s cfg%0d at %0t: got %b, expected %b", name, i, $time, act, exp);
    end
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    for (int i = 0; i < NCFG; i++) begin
      chk("tx", i, tx_a[i], exp_tx(i));
      chk("tx_ready", i, rdy_a[i], exp_ready(i));
      chk("busy", i, busy_a[i], exp_busy(i));
      if (cap_idx < CAPN) begin
        cap_tx[i][cap_idx]   = tx_a[i];
        cap_rdy[i][cap_idx]  = rdy_a[i];
        cap_busy[i][cap_idx] = busy_a[i];
      end
    end
    if (cap_idx < CAPN) cap_idx = cap_idx + 1;
  endtask

  initial begin
    logic [9:0] p47;
    logic [9:0] paa;
    logic [9:0] p01;
    int lows;

    p47 = {1'b1, 8'h47, 1'b0};
    paa = {1'b1, 8'hAA, 1'b0};
    p01 = {1'b1, 8'h01, 1'b0};

    for (int i = 0; i < NCFG; i++) begin
      m_active[i]   = 1'b0;
      m_pos[i]      = 0;
      m_nbits[i]    = 1;
      tx_valid_a[i] = 1'b0;
      tx_data_a[i]  = '0;
    end

    // Reset, then idle with tx_valid low.
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    repeat (20) step();
    chk("idle_tx_lit", 0, tx_a[0], 1'b1);
    chk("idle_ready_lit", 0, rdy_a[0], 1'b1);
    chk("idle_busy_lit", 0, busy_a[0], 1'b0);

    // Single frame on every configuration.
    tx_data_a[0] = 9'h047;
    tx_data_a[1] = 9'h047;
    tx_data_a[2] = 9'h047;
    tx_data_a[3] = 9'h07F;
    tx_data_a[4] = 9'h1A5;
    tx_data_a[5] = 9'h013;
    for (int i = 0; i < NCFG; i++) tx_valid_a[i] = 1'b1;
    cap_idx = 0;
    step();
    for (int i = 0; i < NCFG; i++) begin
      tx_valid_a[i] = 1'b0;
      tx_data_a[i]  = 9'($urandom);
    end
    repeat (49) step();

    for (int j = 0; j < 10; j++) chk("8n1_0x47_bit", j, cap_tx[0][4*j+2], p47[j]);
    chk("8n1_ready_38", 0, cap_rdy[0][38], 1'b0);
    chk("8n1_ready_39", 0, cap_rdy[0][39], 1'b1);
    chk("8n1_busy_39", 0, cap_busy[0][39], 1'b1);
    chk("8n1_busy_40", 0, cap_busy[0][40], 1'b0);
    chk("even_parity_bit", 1, cap_tx[1][38], 1'b0);
    chk("odd_parity_bit", 2, cap_tx[2][38], 1'b1);
    chk("8e1_ready_42", 1, cap_rdy[1][42], 1'b0);
    chk("8e1_ready_43", 1, cap_rdy[1][43], 1'b1);
    chk("8e1_busy_44", 1, cap_busy[1][44], 1'b0);
    lows = 0;
    for (int c = 0; c < 40; c++) if (cap_tx[3][c] === 1'b0) lows = lows + 1;
    tests = tests + 1;
    if (lows != 4) begin
      fails = fails + 1;
      $display("FAIL 7n2_low_cycles: got %0d low cycles, expected 4", lows);
    end
    chk("7n2_start_3", 3, cap_tx[3][3], 1'b0);
    chk("7n2_ready_39", 3, cap_rdy[3][39], 1'b1);
    chk("7n2_busy_40", 3, cap_busy[3][40], 1'b0);

    // Back-to-back frames with tx_valid held high on configuration 0.
    tx_valid_a[0] = 1'b1;
    tx_data_a[0]  = 9'h055;
    cap_idx = 0;
    step();
    tx_data_a[0] = 9'h0AA;
    for (int c = 1; c <= 85; c++) begin
      step();
      if (c == 40) tx_valid_a[0] = 1'b0;
    end
    chk("b2b_stop_39", 0, cap_tx[0][39], 1'b1);
    chk("b2b_start_40", 0, cap_tx[0][40], 1'b0);
    chk("b2b_busy_40", 0, cap_busy[0][40], 1'b1);
    chk("b2b_ready_79", 0, cap_rdy[0][79], 1'b1);
    chk("b2b_busy_79", 0, cap_busy[0][79], 1'b1);
    chk("b2b_busy_80", 0, cap_busy[0][80], 1'b0);
    for (int j = 0; j < 10; j++) chk("b2b_0xaa_bit", j, cap_tx[0][40+4*j+2], paa[j]);

    // Reset during data bit 3, then a clean frame.
    tx_valid_a[0] = 1'b1;
    tx_data_a[0]  = 9'h047;
    cap_idx = 0;
    step();
    tx_valid_a[0] = 1'b0;
    repeat (17) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midreset_tx", 0, cap_tx[0][18], 1'b1);
    chk("midreset_busy", 0, cap_busy[0][18], 1'b0);
    chk("midreset_ready", 0, cap_rdy[0][18], 1'b1);
    step();
    tx_valid_a[0] = 1'b1;
    tx_data_a[0]  = 9'h001;
    cap_idx = 0;
    step();
    tx_valid_a[0] = 1'b0;
    repeat (44) step();
    for (int j = 0; j < 10; j++) chk("after_reset_0x01_bit", j, cap_tx[0][4*j+2], p01[j]);

    // Random traffic with occasional resets.
    cap_idx = CAPN;
    repeat (3000) begin
      for (int i = 0; i < NCFG; i++) begin
        tx_valid_a[i] = ($urandom_range(0, 3) != 0);
        tx_data_a[i]  = 9'($urandom);
      end
      reset_n = ($urandom_range(0, 799) != 0);
      step();
    end
    reset_n = 1'b1;
    for (int i = 0; i < NCFG; i++) tx_valid_a[i] = 1'b0;
    repeat (60) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter. It serialises one parallel word per valid/ready handshake into an asynchronous serial frame on `tx`. The frame is a start bit, DATA_BITS data bits (LSB first), an optional parity bit and 1 or 2 stop bits. Each bit is held for exactly CLKS_PER_BIT clock cycles. The block sits between any byte producer (command FIFO, debug logger) and the board TX pin, and replaces the fixed 8N1, one-bit-per-clock transmitter.

## Interface
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range >= 2
- DATA_BITS, 8, data bits per frame; legal range 5..9
- PARITY, PAR_NONE, parity mode from `uart_pkg`: PAR_NONE, PAR_ODD, PAR_EVEN
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2
- clock  input  1  system clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- tx_valid  input  1  producer has a word on tx_data
- tx_ready  output  1  block can accept a word this cycle
- tx_data  input  DATA_BITS  word to send; sampled only on handshake
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress (state != IDLE)

## Operation
- All outputs are registered. Reset values: tx=1, tx_ready=1, busy=0. Internal bit counter and period counter reset to 0, and state resets to IDLE.
- Handshake: a word is accepted on a rising edge where tx_valid && tx_ready. At that edge:
  - tx_data is latched into the shift register.
  - tx goes to 0 (start bit).
  - tx_ready goes to 0 and busy goes to 1.
- tx_data and tx_valid are don't-care when tx_ready=0. The producer may change them freely.
- States: IDLE -> START -> DATA -> PARITY (skipped when PAR_NONE) -> STOP -> IDLE, or -> START for back-to-back frames.
- Bit period counter: counts 0..CLKS_PER_BIT-1 and wraps. Each state or bit advances on the wrap. Counter width is $clog2(CLKS_PER_BIT).
- DATA state:
  - Sends tx_data[0] first.
  - The bit index counts 0..DATA_BITS-1, width $clog2(DATA_BITS+1).
- Parity bit, computed from the latched word:
  - PAR_EVEN: ^data.
  - PAR_ODD: ~^data.
- STOP state: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length F = (1 + DATA_BITS + (PARITY!=PAR_NONE) + STOP_BITS) * CLKS_PER_BIT cycles.
- tx_ready rises during the last clock cycle of the final stop bit. This allows a gapless back-to-back handshake on the edge that ends the frame.
- If no word is accepted at the end of a frame, the block enters IDLE: tx=1, busy=0, tx_ready stays 1.
- Reset mid-frame: the frame is abandoned and the latched word is discarded. The next edge gives tx=1, tx_ready=1, busy=0. No partial stop bit is emitted.
- Out-of-range parameters: an elaboration-time `$error`.

## Timing
- Latency: the start bit's first cycle begins on the handshake edge. The first data bit appears CLKS_PER_BIT cycles later.
- Handshake at edge k:
  - tx_ready=0 from k to k+F-2.
  - tx_ready=1 at k+F-1.
  - Next possible accept at edge k+F.
- Sustained throughput: one word per F cycles with tx_valid held high. There is no idle cycle between frames.
- busy falls at edge k+F only if no new word is accepted at that edge.

## Structure
- `uart_pkg`: parity enum (PAR_NONE, PAR_ODD, PAR_EVEN) and TX state enum (IDLE, START, DATA, PARITY, STOP). A future uart_rx shares this package.
- Sub-module `uart_bit_timer`:
  - Parameter CLKS_PER_BIT.
  - Inputs clock, reset_n, clear.
  - Output tick, a one-cycle pulse on counter wrap.
  - Instantiated once. It is restarted by `clear` on every handshake.
- Top: state register, shift register, bit/stop counters, parity register, and output registers.

## Test plan
- Reset with tx_valid=0 -> tx=1, tx_ready=1, busy=0, held for 20 cycles.
- CLKS_PER_BIT=4, 8N1, send 0x47 -> tx = 0 | 1,1,1,0,0,0,1,0 | 1, each bit 4 cycles, 40 cycles total. tx_ready=1 at cycle 39.
- Same stimulus with PAR_EVEN -> parity bit 0. With PAR_ODD -> parity bit 1. Frame is 44 cycles.
- tx_valid held high with 0x55 then 0xAA, 8N1, CLKS_PER_BIT=4 -> two frames in exactly 80 cycles. No idle cycle between the stop bit and the second start bit. The second frame carries 0xAA, LSB first.
- DATA_BITS=7, STOP_BITS=2, send 0x7F -> start, seven 1s, two stop bits: 40 cycles total, tx low only during the start bit.
- reset_n=0 for one cycle during data bit 3 -> tx=1, busy=0, tx_ready=1 after the edge. A following send of 0x01 produces a clean, correct frame.
